// File: rtl/syn_current_accum.sv
`default_nettype none
// ============================================================================
// Module   : syn_current_accum
// Brief    : Synaptic current integrator. It gates the shadowed STDP weights
//            with the presynaptic spikes and sums them (stage 1). The sum is
//            folded into a leaky, saturating 8-bit current register (stage 2).
//            A post spike clears the accumulated current.
// Config   : SYN_LEAK_EN - when defined, cur >> LEAK_SHIFT is subtracted on
//            every enabled cycle. When undefined, the block is a pure
//            saturating integrator.
// Revision : 1.0 - initial release
// ============================================================================
module syn_current_accum #(
  parameter int N_PRE      = 4,
  parameter int W_BITS     = 4,
  parameter int LEAK_SHIFT = 2,
  parameter int GAIN_SHIFT = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic [N_PRE-1:0]          pre_spike,
  input  logic [N_PRE*W_BITS-1:0]   weight,
  input  logic                      w_load,
  input  logic                      post_spike,
  output logic [7:0]                current_out,
  output logic                      sat
);

  // Sum width: W_BITS plus enough headroom for N_PRE terms (6 bits by default).
  localparam int c_SUM_W = W_BITS + $clog2(N_PRE);
  // Accumulator arithmetic width. It is wide enough for 255 + (max sum << gain).
  localparam int c_ACC_W = 10;

`ifdef SYN_LEAK_EN
  localparam logic c_LEAK_ON = 1'b1;
`else
  localparam logic c_LEAK_ON = 1'b0;
`endif

  logic [N_PRE*W_BITS-1:0] r_w_sh;
  logic [N_PRE*W_BITS-1:0] w_w_sh_rst;
  logic [c_SUM_W-1:0]      w_sum;
  logic [c_SUM_W-1:0]      r_sum;
  logic [7:0]              r_cur;
  logic                    r_sat;
  logic [c_ACC_W-1:0]      w_cur_ext;
  logic [c_ACC_W-1:0]      w_leak;
  logic [c_ACC_W-1:0]      w_gain;
  logic [c_ACC_W-1:0]      w_nxt;
  logic                    w_clip;

  // Reset value of the shadow: mid-scale (MSB only) in every synapse slot.
  genvar g;
  generate
    for (g = 0; g < N_PRE; g++) begin : g_sh_rst
      assign w_w_sh_rst[g*W_BITS +: W_BITS] = W_BITS'(1) << (W_BITS - 1);
    end
  endgenerate

  // Weight shadow. It loads whenever w_load is high, regardless of en or post_spike.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         r_w_sh <= w_w_sh_rst;
    else if (w_load) r_w_sh <= weight;
  end

  // Gate each shadowed weight with its spike and add them up.
  always_comb begin
    w_sum = '0;
    for (int k = 0; k < N_PRE; k++) begin
      if (pre_spike[k]) w_sum = w_sum + c_SUM_W'(r_w_sh[k*W_BITS +: W_BITS]);
    end
  end

  // Stage 1 register. A post spike discards both the held sum and the spikes on this edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)             r_sum <= '0;
    else if (post_spike) r_sum <= '0;
    else if (en)         r_sum <= w_sum;
  end

  // Next accumulator value. The leak never exceeds cur, so nothing underflows.
  always_comb begin
    w_cur_ext = c_ACC_W'(r_cur);
    w_leak    = c_LEAK_ON ? (w_cur_ext >> LEAK_SHIFT) : '0;
    w_gain    = c_ACC_W'(r_sum) << GAIN_SHIFT;
    w_nxt     = w_cur_ext - w_leak + w_gain;
    w_clip    = (w_nxt > c_ACC_W'(255));
  end

  // Stage 2 register: a saturating current, with a flag for the cycle that clipped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cur <= '0;
      r_sat <= 1'b0;
    end else if (post_spike) begin
      r_cur <= '0;
      r_sat <= 1'b0;
    end else if (en) begin
      r_cur <= w_clip ? 8'hFF : w_nxt[7:0];
      r_sat <= w_clip;
    end
  end

  assign current_out = r_cur;
  assign sat         = r_sat;

endmodule
`default_nettype wire

// File: tb/tb_syn_current_accum.sv
`default_nettype none
// ============================================================================
// Module   : tb_syn_current_accum
// Brief    : Self-checking bench for syn_current_accum. It uses directed
//            scenarios and a randomized run, checked against a cycle-level
//            behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_syn_current_accum;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [3:0]  pre_spike = '0;
  logic [15:0] weight = '0;
  logic        w_load = 1'b0;
  logic        post_spike = 1'b0;
  logic [7:0]  current_out;
  logic        sat;

  int errors = 0;
  int checks = 0;

  // Behavioural model state, held as plain integers.
  int m_w[4];
  int m_sum;
  int m_cur;
  bit m_sat;

  syn_current_accum dut (
    .clk(clk), .rst(rst), .en(en), .pre_spike(pre_spike), .weight(weight),
    .w_load(w_load), .post_spike(post_spike), .current_out(current_out), .sat(sat)
  );

  always #5 clk = ~clk;

  // Put the model into the reset state.
  task automatic model_reset();
    for (int k = 0; k < 4; k++) m_w[k] = 8;
    m_sum = 0; m_cur = 0; m_sat = 0;
  endtask

  // Apply one rising edge to the model, using the inputs present at that edge.
  task automatic model_edge();
    int nxt, s;
    s = 0;
    for (int k = 0; k < 4; k++) if (pre_spike[k]) s += m_w[k];
    if (post_spike) begin
      m_cur = 0; m_sat = 0; m_sum = 0;
    end else if (en) begin
`ifdef SYN_LEAK_EN
      nxt = m_cur - m_cur / 4 + m_sum * 2;
`else
      nxt = m_cur + m_sum * 2;
`endif
      if (nxt > 255) begin m_cur = 255; m_sat = 1; end
      else begin m_cur = nxt; m_sat = 0; end
      m_sum = s;
    end
    if (w_load) for (int k = 0; k < 4; k++) m_w[k] = (weight >> (4*k)) & 15;
  endtask

  // Advance one clock. The inputs stay stable across the edge and outputs settle 1 ns later.
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checks++;
    if (current_out !== 8'd0 || sat !== 1'b0) begin
      errors++;
      $display("FAIL reset: current_out=%0d sat=%0b, want 0/0", current_out, sat);
    end
  endtask

  task automatic test_single_spike_leak();
    int exp_leak[5];
`ifdef SYN_LEAK_EN
    exp_leak = '{30, 23, 18, 14, 11};
`else
    exp_leak = '{30, 30, 30, 30, 30};
`endif
    en = 1; weight = 16'hF000; w_load = 1;
    tick();
    w_load = 0; pre_spike = 4'b1000;
    tick();
    pre_spike = 4'b0000;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (current_out !== 8'(exp_leak[i]) || current_out !== 8'(m_cur)) begin
        errors++;
        $display("FAIL single_leak[%0d]: current_out=%0d, want %0d", i, current_out, exp_leak[i]);
      end
    end
  endtask

  task automatic test_enable_hold();
    int held;
    // Restart from a single spike so the current is 30, and then 23 with leak.
    post_spike = 1; tick(); post_spike = 0;
    pre_spike = 4'b1000; tick(); pre_spike = 0;
    tick(); tick();
    held = m_cur;
    en = 0;
    for (int i = 0; i < 3; i++) begin
      pre_spike = 4'(i + 9);
      tick();
      checks++;
      if (current_out !== 8'(held)) begin
        errors++;
        $display("FAIL enable_hold[%0d]: current_out=%0d, want %0d", i, current_out, held);
      end
    end
    pre_spike = 0; en = 1;
    tick();
    checks++;
    if (current_out !== 8'(m_cur) || m_cur == held && held > 3 && m_cur != 30) begin
      errors++;
      $display("FAIL enable_resume: current_out=%0d, want %0d", current_out, m_cur);
    end
  endtask

  task automatic test_saturation();
    int exp_s[4];
`ifdef SYN_LEAK_EN
    exp_s = '{120, 210, 255, 255};
`else
    exp_s = '{120, 240, 255, 255};
`endif
    post_spike = 1; weight = 16'hFFFF; w_load = 1; tick();
    post_spike = 0; w_load = 0; pre_spike = 4'b1111;
    tick();
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (current_out !== 8'(exp_s[i]) || sat !== (i >= 2)) begin
        errors++;
        $display("FAIL saturation[%0d]: current_out=%0d sat=%0b, want %0d/%0b",
                 i, current_out, sat, exp_s[i], (i >= 2));
      end
    end
  endtask

  task automatic test_clear_priority();
    post_spike = 1; tick(); post_spike = 0;
    pre_spike = 4'b1111; tick(); tick(); tick();   // current is now 120 followed by 210
    post_spike = 1;
    tick();
    post_spike = 0;
    checks++;
    if (current_out !== 8'd0 || sat !== 1'b0) begin
      errors++;
      $display("FAIL clear_priority: current_out=%0d sat=%0b, want 0/0", current_out, sat);
    end
    // The spikes on the clear edge were dropped, so this edge adds nothing.
    tick();
    checks++;
    if (current_out !== 8'd0) begin
      errors++;
      $display("FAIL clear_drop: current_out=%0d, want 0", current_out);
    end
    tick();
    checks++;
    if (current_out !== 8'd120) begin
      errors++;
      $display("FAIL clear_next: current_out=%0d, want 120", current_out);
    end
    pre_spike = 0;
  endtask

  task automatic test_shadow_timing();
    // Reset so the shadow starts at 16'h8888.
    @(negedge clk); rst = 1; model_reset(); @(negedge clk); rst = 0;
    en = 1; pre_spike = 4'b0001; weight = 16'h0001; w_load = 1;
    tick();
    w_load = 0; pre_spike = 4'b0001;
    tick();
    checks++;
    if (current_out !== 8'd16) begin
      errors++;
      $display("FAIL shadow_old: current_out=%0d, want 16", current_out);
    end
    pre_spike = 0;
    tick();
    checks++;
    if (current_out !== 8'(m_cur)) begin
      errors++;
      $display("FAIL shadow_new: current_out=%0d, want %0d", current_out, m_cur);
    end
  endtask

  task automatic test_async_reset();
    weight = 16'h0000; w_load = 1; pre_spike = 4'b1111; tick(); w_load = 0;
    pre_spike = 4'b0001; tick(); tick();
    #2 rst = 1;
    #1;
    checks++;
    if (current_out !== 8'd0 || sat !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: current_out=%0d sat=%0b, want 0/0", current_out, sat);
    end
    model_reset();
    @(negedge clk); rst = 0;
    pre_spike = 4'b0001; tick(); pre_spike = 0; tick();
    checks++;
    if (current_out !== 8'd16) begin
      errors++;
      $display("FAIL async_reset_wsh: current_out=%0d, want 16", current_out);
    end
  endtask

  task automatic test_random();
    int bad = 0;
    for (int i = 0; i < 400; i++) begin
      en         = ($urandom_range(0, 9) != 0);
      pre_spike  = 4'($urandom);
      w_load     = ($urandom_range(0, 7) == 0);
      weight     = 16'($urandom);
      post_spike = ($urandom_range(0, 19) == 0);
      tick();
      checks++;
      if (current_out !== 8'(m_cur) || sat !== m_sat) begin
        errors++;
        if (bad < 10)
          $display("FAIL random[%0d]: current_out=%0d sat=%0b, want %0d/%0b",
                   i, current_out, sat, m_cur, m_sat);
        bad++;
      end
    end
    post_spike = 0; w_load = 0; pre_spike = 0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single_spike_leak();
    test_enable_hold();
    test_saturation();
    test_clear_priority();
    test_shadow_timing();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/syn_current_accum.md
# syn_current_accum

Synaptic current integrator that sits between the STDP weight array and the postsynaptic LIF neuron. Each cycle it gates four 4-bit learned weights by the four presynaptic spikes and sums them. It folds the sum into a leaky, saturating 8-bit current register, which drives the post neuron's `current` input. A post spike clears the accumulated current, giving a reset-after-fire synapse.

## Interface
Parameters:
- `N_PRE`, 4: presynaptic inputs.
- `W_BITS`, 4: bits per weight.
- `LEAK_SHIFT`, 2: leak per cycle is `cur >> LEAK_SHIFT`.
- `GAIN_SHIFT`, 1: weighted sum is scaled by `<< GAIN_SHIFT` before it is added.

Ports:
- `clk`, input, 1: single clock. All state changes on the rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `en`, input, 1: advance enable. Low freezes stage 1 and the accumulator.
- `pre_spike`, input, N_PRE: presynaptic spikes. Bit k pairs with `weight[k*W_BITS +: W_BITS]`, so bit 3 pairs with `[15:12]`.
- `weight`, input, N_PRE*W_BITS: live weight bus from the STDP block.
- `w_load`, input, 1: latches `weight` into the shadow register.
- `post_spike`, input, 1: postsynaptic fire. Clears the current.
- `current_out`, output, 8: accumulated synaptic current, registered.
- `sat`, output, 1: registered. High for the cycle in which the accumulator clipped at 255.

## Operation
- **Weight shadow `w_sh`.**
  - Loaded from `weight` on any edge with `w_load`=1, independent of `en`.
  - Stage 1 uses only `w_sh`, so a weight update in flight never glitches the sum.
- **Stage 1 (en=1).**
  - `sum <= Σ_k pre_spike[k] ? w_sh[k] : 0`.
  - Width is W_BITS+2 (6 bits); maximum 60.
- **Stage 2 (en=1).**
  - `nxt = cur − (cur >> LEAK_SHIFT) + (sum << GAIN_SHIFT)`, computed 10 bits wide and unsigned.
  - The leak term is never larger than `cur`, so `nxt` never underflows.
  - If `nxt > 255`: `cur <= 255`, `sat <= 1`. Otherwise `cur <= nxt`, `sat <= 0`.
- **post_spike=1 (any `en`).**
  - `cur <= 0`, `sat <= 0`, `sum <= 0`.
  - The sum in stage 1 is discarded, and `pre_spike` sampled on that edge is also dropped.
  - `post_spike` takes priority over any simultaneous `pre_spike`, `w_load` or `en`.
- **en=0, no post_spike.**
  - `sum`, `cur` and `sat` hold.
  - `pre_spike` is ignored and not queued.
- **Reset values.**
  - `sum`=0, `cur`=0 (`current_out`=0), `sat`=0.
  - `w_sh`=16'h8888, a mid-scale weight in each synapse.
- **Reset timing.** Reset asserted mid-operation clears all of the above immediately (asynchronous). The first accumulation occurs on the first edge after `rst` falls.

## Timing
- **Spike to output.** `pre_spike` sampled at edge t reaches `current_out` after edge t+1: 2 edges, 1 cycle of pipeline.
- **Weight load.** `w_load` at edge t affects `pre_spike` sampled at edge t+1 and later. A `pre_spike` on the same edge t uses the old `w_sh`.
- **post_spike clear.** `post_spike` at edge t gives `current_out`=0 after edge t. The next nonzero contribution can come only from `pre_spike` sampled at edge t+1, visible after t+2.
- **Saturation flag.** `sat` is visible in the same cycle as the clipped `current_out`.
- **No handshakes.** There is no backpressure; the block accepts one spike vector per enabled cycle.

## Configuration
- **`SYN_LEAK_EN` defined:** the leak term `cur >> LEAK_SHIFT` is subtracted each enabled cycle, as described above.
- **`SYN_LEAK_EN` undefined:**
  - The leak term is 0, giving a pure saturating integrator: `nxt = cur + (sum << GAIN_SHIFT)`.
  - `LEAK_SHIFT` is unused.
  - All other behaviour is unchanged.

## Test plan
All scenarios use default parameters and `SYN_LEAK_EN` defined, except where noted.
- **Single spike and leak.** Reset, `w_load` with 16'hF000, then `pre_spike`=4'b1000 for one cycle with en=1.
  - `current_out` is 30 after 2 edges, then decays 23, 18, 14, 11 on the following edges.
- **Saturation.** `w_load` 16'hFFFF, `pre_spike`=4'b1111 held.
  - `current_out` goes 120, 210, 255 with `sat`=1 on the third update, then stays 255.
  - With `SYN_LEAK_EN` undefined: 120, 240, 255 (`sat`=1).
- **Clear priority.** While `current_out`=210, assert `post_spike` together with `pre_spike`=4'b1111.
  - `current_out`=0 and `sat`=0 next cycle.
  - The following value is 120 only if `pre_spike` is still high on the next edge.
- **Shadow timing.** `w_load` 16'h0001 on the same edge as `pre_spike`=4'b0001, with the shadow at reset value 16'h8888.
  - The contribution uses the old weight 8 (`current_out`=16).
  - `pre_spike` on the next edge uses weight 1.
- **Enable hold.** With `current_out`=23, drop en for 3 cycles while toggling `pre_spike`.
  - Output holds 23; no leak and no accumulation.
  - Leak resumes on re-enable.
- **Async reset.** Pulse `rst` between edges mid-accumulation.
  - `current_out`=0 and `sat`=0 immediately, with `w_sh` back to 16'h8888.
